// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, XLEN, PC step.
package fetch_pkg;
  localparam int          XLEN    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between fetch_ctrl (master) and imem (slave).
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives the PC write port, one-outstanding imem requests and the IF/ID slot.
// Optional trap override is compiled in with `define FETCH_CTRL_TRAP_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_we,
  output logic [XLEN-1:0] next_pc,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_CTRL_TRAP_EN
  input  logic            trap,
`endif
  fetch_ctrl_if.master    imem,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  fetch_state_e    state_q;
  logic            if_valid_q;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_instr_q;

  logic            ovr;
  logic [XLEN-1:0] ovr_pc;
  logic            req;
  logic            capture;

  // Trap and redirect share one override path; trap takes precedence.
`ifdef FETCH_CTRL_TRAP_EN
  assign ovr    = trap | redirect_valid;
  assign ovr_pc = trap ? TRAP_VEC : redirect_pc;
`else
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
  assign ovr    = redirect_valid;
  assign ovr_pc = redirect_pc;
`endif

  // Only request when the slot will be free by the time the response lands.
  assign req     = !reset && (state_q == REQ) && (!if_valid_q || !stall);
  assign capture = (state_q == WAIT) && imem.imem_rvalid && !ovr;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  always_comb begin
    pc_we   = 1'b0;
    next_pc = pc;
    if (!reset) begin
      if (state_q == BOOT) begin
        pc_we   = 1'b1;
        next_pc = RESET_PC;
      end else if (ovr) begin
        pc_we   = 1'b1;
        next_pc = ovr_pc;
      end else if (capture) begin
        pc_we   = 1'b1;
        next_pc = pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      unique case (state_q)
        BOOT:  state_q <= REQ;
        // A grant coinciding with an override fetched the old PC, so drain it.
        REQ:   if (req && imem.imem_gnt) state_q <= ovr ? DRAIN : WAIT;
        WAIT:  if (imem.imem_rvalid) state_q <= REQ;
               else if (ovr)         state_q <= DRAIN;
        DRAIN: if (imem.imem_rvalid) state_q <= REQ;
        default: state_q <= BOOT;
      endcase

      if (state_q != BOOT) begin
        if (ovr) begin
          if_valid_q <= 1'b0;
        end else if (capture) begin
          if_valid_q <= 1'b1;
          if_pc_q    <= pc;
          if_instr_q <= imem.imem_rdata;
        end else if (if_valid_q && !stall) begin
          if_valid_q <= 1'b0;
        end
      end
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: flag-based reference model checked every cycle, plus directed pins.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'hDEAD_BEEF;
  logic        pc_we;
  logic [31:0] next_pc;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;

  fetch_ctrl_if imem();

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pc_we          (pc_we),
    .next_pc        (next_pc),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_CTRL_TRAP_EN
    .trap           (trap),
`endif
    .imem           (imem),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  // External PC register fed by the controller's write port
  always @(posedge clk) if (pc_we) pc <= next_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event, expected one within 20 cycles", name);
  endtask

  // ---------------- reference model (abstract flags, not FSM states) ----------------
  bit          m_known, m_booted, m_out, m_stale, m_v;
  logic [31:0] m_pc, m_instr;

  always @(negedge clk) begin : model
    logic        ovr, e_req, e_we, cap;
    logic [31:0] tgt, e_np;
    ovr  = trap || redirect_valid;
    tgt  = trap ? TVEC : redirect_pc;
    e_np = '0;
    if (reset) begin
      e_req = 1'b0; e_we = 1'b0;
    end else if (!m_booted) begin
      e_req = 1'b0; e_we = 1'b1; e_np = RST_PC;
    end else begin
      e_req = !m_out && (!m_v || !stall);
      if (ovr) begin
        e_we = 1'b1; e_np = tgt;
      end else if (m_out && !m_stale && imem.imem_rvalid) begin
        e_we = 1'b1; e_np = pc + 32'd4;
      end else begin
        e_we = 1'b0;
      end
    end

    chk("pc_we", {31'b0, pc_we}, {31'b0, e_we});
    if (e_we) chk("next_pc", next_pc, e_np);
    chk("imem_req", {31'b0, imem.imem_req}, {31'b0, e_req});
    if (e_req) chk("imem_addr", imem.imem_addr, pc);
    if (m_known) begin
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_v});
      chk("if_pc", if_pc, m_pc);
      chk("if_instr", if_instr, m_instr);
    end

    if (reset) begin
      m_known = 1; m_booted = 0; m_out = 0; m_stale = 0; m_v = 0;
      m_pc = '0; m_instr = '0;
    end else if (!m_booted) begin
      m_booted = 1;
    end else begin
      cap = m_out && imem.imem_rvalid && !m_stale && !ovr;
      if (m_out) begin
        if (imem.imem_rvalid) begin m_out = 0; m_stale = 0; end
        else m_stale = m_stale || ovr;
      end else if (e_req && imem.imem_gnt) begin
        m_out = 1; m_stale = ovr;
      end
      if (ovr) m_v = 0;
      else if (cap) begin m_v = 1; m_pc = pc; m_instr = imem.imem_rdata; end
      else if (m_v && !stall) m_v = 0;
    end
  end

  // ---------------- memory model + cycle stepping ----------------
  bit          pend, gnt_all;
  int          cnt, lat_lo, lat_hi;
  logic [31:0] paddr;

  task automatic step();
    bit          g;
    logic [31:0] a;
    @(negedge clk);
    g = imem.imem_req && imem.imem_gnt;
    a = imem.imem_addr;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    trap = 1'b0;
    if (g) begin pend = 1; cnt = $urandom_range(lat_hi, lat_lo); paddr = a; end
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = $urandom();
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = mem_word(paddr);
        pend = 0;
      end
    end
    imem.imem_gnt = !pend && (gnt_all || ($urandom_range(0, 99) < 60));
    #1;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin step(); n++; end while (!if_valid && n < 20);
    if (!if_valid) tmo(name);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    do begin step(); n++; end while (!imem.imem_req && n < 20);
    if (!imem.imem_req) tmo(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    pend = 0; gnt_all = 1; lat_lo = 1; lat_hi = 1;

    // Boot
    step(); step();
    reset = 1'b0;
    #1;
    chk("boot_pc_we", {31'b0, pc_we}, 32'd1);
    chk("boot_next_pc", next_pc, 32'h0);
    step();
    chk("boot_req", {31'b0, imem.imem_req}, 32'd1);
    chk("boot_addr", imem.imem_addr, 32'h0);

    // Straight-line, zero-wait memory: 0, 4, 8 every other cycle
    for (int k = 0; k < 3; k++) begin
      wait_valid("seq_wait", n);
      chk("seq_pc", if_pc, 32'(4 * k));
      chk("seq_gap", n, 2);
      chk("seq_instr", if_instr, mem_word(32'(4 * k)));
      if (k == 2) stall = 1'b1;
    end

    // Stall hold on slot 8
    for (int s = 0; s < 3; s++) begin
      if (s > 0) step();
      #1;
      chk("stall_req", {31'b0, imem.imem_req}, 32'd0);
      chk("stall_slot", if_pc, 32'd8);
      chk("stall_valid", {31'b0, if_valid}, 32'd1);
      chk("stall_pc", pc, 32'd12);
    end
    step();
    stall = 1'b0;
    #1;
    chk("release_req", {31'b0, imem.imem_req}, 32'd1);
    chk("release_addr", imem.imem_addr, 32'd12);
    step();
    chk("consumed", {31'b0, if_valid}, 32'd0);
    wait_valid("pc12_wait", n);
    chk("pc12", if_pc, 32'd12);

    // Redirect while a slow response is outstanding
    lat_lo = 3; lat_hi = 3;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    chk("redir_we", {31'b0, pc_we}, 32'd1);
    chk("redir_next_pc", next_pc, 32'h200);
    step();
    lat_lo = 1; lat_hi = 1;
    chk("redir_slot_clear", {31'b0, if_valid}, 32'd0);
    chk("redir_drain_req", {31'b0, imem.imem_req}, 32'd0);
    wait_req("redir_req_wait");
    chk("redir_addr", imem.imem_addr, 32'h200);
    wait_valid("redir_valid_wait", n);
    chk("redir_if_pc", if_pc, 32'h200);
    chk("redir_if_instr", if_instr, mem_word(32'h200));

    // Redirect coinciding with a grant, then wrap-around
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("gnt_redir_req", {31'b0, imem.imem_req & imem.imem_gnt}, 32'd1);
    chk("gnt_redir_next_pc", next_pc, 32'hFFFF_FFFC);
    step();
    chk("drain_no_req", {31'b0, imem.imem_req}, 32'd0);
    wait_req("wrap_req_wait");
    chk("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap_valid_wait", n);
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'h0);
    wait_valid("wrap0_wait", n);
    chk("wrap0_if_pc", if_pc, 32'h0);

`ifdef FETCH_CTRL_TRAP_EN
    trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    #1;
    chk("trap_wins", next_pc, 32'h100);
    step();
`endif

    // Randomized phase
    gnt_all = 0; lat_lo = 1; lat_hi = 4;
    for (int c = 0; c < 4000; c++) begin
      step();
      reset = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 6) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      end
`ifdef FETCH_CTRL_TRAP_EN
      if ($urandom_range(0, 99) < 2) trap = 1'b1;
`endif
    end
    reset = 1'b0; stall = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
